adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one combinational 8-bit add/subtract unit (`eightBitAdder`) among NUM_REQ requesters in the matrix datapath.
- A round-robin arbiter grants one requester per cycle and drives its operands onto the shared adder.
- The adder result is registered and returned, tagged with the requester ID, over a valid/ready response channel.
- Sits between the matrix row/column element engines and the single adder instance.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- WIDTH, 8, operand width; fixed at 8 to match the adder.
- ID_W, 2, requester ID width; equals clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B+cin.
- req_cin  input  NUM_REQ  carry-in; ignored when req_sub=1.
- add_a  output  WIDTH  to adder a.
- add_b  output  WIDTH  to adder b (un-inverted; the adder applies the subtract XOR).
- add_cin  output  1  to adder Cin0.
- add_sub  output  1  to adder subtract.
- add_sum  input  WIDTH  from adder sum.
- add_cout  input  1  from adder C7.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry-out; for subtract, 1 means no borrow.
- rsp_ovf  output  1  registered signed overflow.

Behaviour:
- Reset (synchronous, active-high): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0. last_grant=NUM_REQ-1, so requester 0 has top priority. FSM enters ISSUE.
- FSM states:
  - ISSUE: the output slot is free, or it is being drained this cycle (rsp_valid=0 or rsp_ready=1).
  - HOLD: rsp_valid=1 and rsp_ready=0.
- Transitions:
  - ISSUE→HOLD when the captured response is not accepted the next cycle.
  - HOLD→ISSUE on rsp_ready=1.
- Grant is combinational in ISSUE:
  - Search req_valid starting at (last_grant+1) mod NUM_REQ and wrap; the first asserted index is granted.
  - req_ready is one-hot at that index, and all zero if no request is valid or the FSM is in HOLD.
- Adder muxing:
  - Adder inputs come from the granted requester.
  - When no grant is active, adder inputs are 0 with add_sub=0, so there are no X's on the shared unit.
- Transfer occurs on req_valid[i] & req_ready[i]. At that edge:
  - rsp_sum←add_sum, rsp_cout←add_cout, rsp_id←i, rsp_valid←1, last_grant←i.
  - Latency: 1 cycle from transfer to rsp_valid.
- Overflow: rsp_ovf = (a[7] == beff[7]) && (add_sum[7] != a[7]), where beff = b XOR {8{sub}}.
- Subtract semantics match the adder: a + ~b + 1; cin has no effect.
- Response handshake:
  - rsp_valid & rsp_ready at an edge with no new transfer → rsp_valid←0.
  - Simultaneous drain and new transfer → the slot is overwritten with new data and rsp_valid stays 1.
  - Back-to-back throughput is 1 operation per cycle.
- Pointer and requester stability:
  - last_grant changes only on a transfer; an idle cycle does not rotate priority.
  - Requesters hold operands stable while valid is high and ready is low. The arbiter never drops an asserted request.
- Fairness: with all requesters continuously valid and rsp_ready=1, grant order is 0,1,2,3,0,... Every requester is served within NUM_REQ transfers.
- Reset mid-operation: any pending response is discarded, the pointer is reset, and req_ready is all 0 during the reset cycle.

Decomposition:
- Shared package holds:
  - Constants: ADD_WIDTH=8, MAX_REQ=8.
  - FSM state typedef: ISSUE, HOLD.
  - Helper function clog2.
- One natural sub-module, rr_picker. It is combinational: inputs are request vector and last_grant; outputs are one-hot grant and index. It is reusable by other matrix arbiters.
- The adder stays external, instantiated by the parent, so the arbiter can be verified against a behavioural model.

Test Plan:
- Single request: reset, then req0 a=8'h05, b=8'h03, sub=0, cin=1 → req_ready=4'b0001 same cycle. Next cycle rsp_valid=1, id=0, sum=8'h09, cout=0, ovf=0.
- Subtract with borrow: req2 a=8'h03, b=8'h05, sub=1, cin=0 → sum=8'hFE, cout=0, ovf=0. Repeat with cin=1: result identical.
- Signed overflow: req1 a=8'h7F, b=8'h01, sub=0, cin=0 → sum=8'h80, ovf=1, cout=0. Also a=8'hFF, b=8'h01 → sum=8'h00, cout=1, ovf=0.
- Round-robin fairness: all four requesters continuously valid with distinct operands, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 and one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after the first response → req_ready=0 and rsp fields stable throughout. On rsp_ready=1, the next grant goes to last_grant+1.
- Mid-stream reset: reset asserted while rsp_valid=1 → next cycle all rsp outputs are 0. The first grant after reset goes to requester 0 even if requester 3 was next.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter and its round-robin picker.
package adder_share_arbiter_pkg;

  localparam int ADD_WIDTH = 8;
  localparam int MAX_REQ   = 8;

  typedef enum logic {
    ISSUE = 1'b0,
    HOLD  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module rr_picker
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Scan from last_grant+1 around the ring; the first hit wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!gnt_any && req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external 8-bit add/subtract unit among NUM_REQ requesters with
// round-robin arbitration and a registered, ID-tagged valid/ready response.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ADD_WIDTH,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  output logic                     add_sub,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_ovf
);

  arb_state_e          state;
  logic                grant_en;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [ID_W-1:0]     last_grant;
  logic [WIDTH-1:0]    b_eff;
  logic                ovf_now;

  // Signed overflow of a + b_eff: operand signs agree but the result sign differs.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // HOLD while a captured response is waiting on a stalled consumer; the slot
  // can be refilled in the same cycle it is drained, so this is decoded live.
  always_comb begin
    state = (rsp_valid && !rsp_ready) ? HOLD : ISSUE;
  end

  assign grant_en  = !reset && (state == ISSUE);
  assign pick_req  = req_valid & {NUM_REQ{grant_en}};
  assign req_ready = gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req        (pick_req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Route the granted requester onto the shared adder; idle drives zeros.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    add_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        add_a   = req_a[i*WIDTH +: WIDTH];
        add_b   = req_b[i*WIDTH +: WIDTH];
        add_sub = req_sub[i];
        // Subtract is a + ~b + 1, so the carry-in is forced high.
        add_cin = req_sub[i] ? 1'b1 : req_cin[i];
      end
    end
  end

  assign b_eff   = add_b ^ {WIDTH{add_sub}};
  assign ovf_now = signed_ovf(add_a, b_eff, add_sum);

  // ---- stage boundary: adder result captured into the response slot ----
  // Capture on transfer, release the slot on drain, move the pointer only on transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (gnt_any) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_idx;
      rsp_sum    <= add_sum;
      rsp_cout   <= add_cout;
      rsp_ovf    <= ovf_now;
      last_grant <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with an arithmetic reference model.
module tb_adder_share_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid, req_ready, req_sub, req_cin;
  logic [N*8-1:0] req_a, req_b;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_sub, add_cout;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_sum;

  logic [7:0]   va [N];
  logic [7:0]   vb [N];
  logic [N-1:0] vv, vs, vc;
  logic [N-1:0] seen_rdy = '0;
  bit           hold_req;

  int n_vec  = 0;
  int n_miss = 0;

  // model state (m_) and its next value (n_), reset values at time 0
  logic       m_vld = 0, n_vld = 0;
  int         m_id  = 0, n_id  = 0;
  logic [7:0] m_sum = 0, n_sum = 0;
  logic       m_co  = 0, n_co  = 0;
  logic       m_ov  = 0, n_ov  = 0;
  int         m_ptr = N-1, n_ptr = N-1;

  adder_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // the external eightBitAdder
  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {8{add_sub}}} + {8'b0, add_cin};

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = va[i];
      req_b[i*8 +: 8] = vb[i];
    end
  end
  assign req_valid = vv;
  assign req_sub   = vs;
  assign req_cin   = vc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // arithmetic meaning of one operation
  task automatic calc(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                      output logic [7:0] sum, output logic co, output logic ov);
    int r, sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      r  = int'(a) - int'(b);
      sr = sa - sb;
      co = (a >= b);
    end else begin
      r  = int'(a) + int'(b) + int'(c);
      sr = sa + sb + int'(c);
      co = (r > 255);
    end
    sum = 8'(r);
    ov  = (sr > 127) || (sr < -128);
  endtask

  // compare DUT against the model every cycle and prepare the model's next state
  always @(negedge clk) begin
    int c, gi;
    logic found;
    logic [N-1:0] eg;
    logic [7:0] s;
    logic co, ov;
    chk("rsp_valid", rsp_valid, m_vld);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_sum", rsp_sum, m_sum);
    chk("rsp_cout", rsp_cout, m_co);
    chk("rsp_ovf", rsp_ovf, m_ov);
    eg = '0; found = 0; gi = 0;
    if (!reset && !(m_vld && !rsp_ready)) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && vv[c]) begin
          found = 1; gi = c; eg[c] = 1'b1;
        end
      end
    end
    chk("req_ready", req_ready, eg);
    if (!found) chk("adder_idle", {add_a, add_b, add_sub}, 0);
    seen_rdy = req_ready;
    n_vld = m_vld; n_id = m_id; n_sum = m_sum; n_co = m_co; n_ov = m_ov; n_ptr = m_ptr;
    if (reset) begin
      n_vld = 0; n_id = 0; n_sum = 0; n_co = 0; n_ov = 0; n_ptr = N-1;
    end else if (found) begin
      calc(va[gi], vb[gi], vs[gi], vc[gi], s, co, ov);
      n_vld = 1; n_id = gi; n_sum = s; n_co = co; n_ov = ov; n_ptr = gi;
    end else if (rsp_ready) begin
      n_vld = 0;
    end
  end

  always @(posedge clk) begin
    m_vld <= n_vld; m_id <= n_id; m_sum <= n_sum;
    m_co  <= n_co;  m_ov <= n_ov; m_ptr <= n_ptr;
  end

  // advance one cycle; requesters withdraw once accepted unless holding
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_req)
      for (int i = 0; i < N; i++) if (seen_rdy[i]) vv[i] = 1'b0;
  endtask

  task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c,
                        input logic [7:0] es, input logic eco, input logic eov);
    va[i] = a; vb[i] = b; vs[i] = s; vc[i] = c; vv[i] = 1'b1;
    @(negedge clk);
    chk("single_ready", req_ready, 32'(1 << i));
    step();
    @(negedge clk);
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, i);
    chk("single_sum", rsp_sum, es);
    chk("single_cout", rsp_cout, eco);
    chk("single_ovf", rsp_ovf, eov);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; hold_req = 0;
    vv = '0; vs = '0; vc = '0;
    for (int i = 0; i < N; i++) begin va[i] = '0; vb[i] = '0; end
    repeat (2) step();
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_ready", req_ready, 0);
    step();
    reset = 1'b0;

    single(0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0);
    single(2, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    single(2, 8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    single(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    single(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // fairness: everyone valid, consumer always ready
    reset = 1'b1;
    step();
    reset = 1'b0; hold_req = 1;
    va[0] = 8'h11; vb[0] = 8'h22; va[1] = 8'h20; vb[1] = 8'h0F;
    va[2] = 8'h7F; vb[2] = 8'h80; va[3] = 8'h80; vb[3] = 8'h80;
    vs = 4'b1010; vc = 4'b0110; vv = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      step();
      @(negedge clk);
      chk("fair_id", rsp_id, n % 4);
      chk("fair_valid", rsp_valid, 1);
    end

    // backpressure after the first response
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_sum", rsp_sum, 8'h33);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0010);

    // mid-stream reset while a response is pending and requester 3 is next
    step();
    @(negedge clk);
    chk("pre_rst_grant", req_ready, 4'b0100);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("in_rst_ready", req_ready, 0);
    chk("in_rst_valid", rsp_valid, 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_sum", rsp_sum, 0);
    chk("post_rst_grant", req_ready, 4'b0001);

    // mixed traffic with stalls; waiting requesters keep their operands
    hold_req = 0;
    for (int n = 0; n < 80; n++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!vv[i] && $urandom_range(0, 1) == 1) begin
          vv[i] = 1'b1;
          va[i] = 8'($urandom);
          vb[i] = 8'($urandom);
          vs[i] = 1'($urandom);
          vc[i] = 1'($urandom);
        end
      end
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
